// File: rtl/johnson_sequencer.sv
// Johnson counter sequencer.
// Turns start/stop button levels and mode/direction switches into the
// enable, direction and clear controls for a 16-bit Johnson counter.
// Steps are issued as single-cycle enables at a programmable prescale
// rate. Three sweep modes are supported:
//   - continuous:  steps run forever and the step count saturates
//   - bounce:      the direction reverses every SPAN steps
//   - single-shot: the sequencer halts after SPAN steps
module johnson_sequencer #(
  parameter int unsigned PSC  = 100000,  // system-clock cycles per step, 1..2^24-1
  parameter int unsigned SPAN = 32       // steps per sweep, 1..255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [1:0] mode_i,
  input  logic       dir_i,
  output logic       step_en_o,
  output logic       dir_o,
  output logic       cnt_clr_o,
  output logic [1:0] state_o,
  output logic [7:0] steps_o,
  output logic       done_o
);

  // Encodings are visible on state_o, so they are fixed explicitly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_RUN   = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  // The reserved switch setting 11 is folded into continuous when it is
  // latched, so the mode register only ever holds these three values.
  typedef enum logic [1:0] {
    MODE_CONT   = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_SINGLE = 2'b10
  } mode_e;

  localparam logic [23:0] PSC_LAST  = 24'(PSC - 1);
  localparam logic [7:0]  SPAN_LAST = 8'(SPAN - 1);
  localparam logic [7:0]  STEPS_MAX = 8'hFF;

  // Button edge-detect history.
  logic start_q1;
  logic start_q2;
  logic stop_q1;
  logic stop_q2;
  logic start_edge;
  logic stop_edge;

  // Control state and datapath registers.
  state_e      state_q;
  state_e      state_d;
  mode_e       mode_q;
  mode_e       mode_sel;
  logic        dir_q;
  logic [7:0]  steps_q;
  logic [23:0] psc_q;
  logic        done_q;

  // Decoded controls.
  logic tick;
  logic span_hit;
  logic step_en;
  logic clr_en;
  logic load_cfg;

  // Two-stage history per button. Resetting the history to 1 means a
  // button already held through reset looks "still pressed", so it has to
  // be released and pressed again before it registers.
  always_ff @(posedge clk_i) begin
    // NOTE: every register in a clocked block uses <=, so all flops update
    // together from the values present before the edge.
    if (!rst_ni) begin
      start_q1 <= 1'b1;
      start_q2 <= 1'b1;
      stop_q1  <= 1'b1;
      stop_q2  <= 1'b1;
    end else begin
      start_q1 <= start_i;
      start_q2 <= start_q1;
      stop_q1  <= stop_i;
      stop_q2  <= stop_q1;
    end
  end

  // Rising edges come from registered history only. Because of this, the
  // outputs never depend combinationally on the raw button pins.
  assign start_edge = start_q1 & ~start_q2;
  assign stop_edge  = stop_q1 & ~stop_q2;

  // The prescaler wraps at PSC-1. That wrap point is the step tick.
  assign tick     = (state_q == ST_RUN) && (psc_q == PSC_LAST);
  assign span_hit = (steps_q == SPAN_LAST);

  // Map the reserved mode setting onto continuous at the latch point.
  assign mode_sel = (mode_i == 2'b11) ? MODE_CONT : mode_e'(mode_i);

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-cycle control decode.
  // Priority order: a stop edge wins over a start edge, and a start edge
  // wins over a prescale tick.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    step_en  = 1'b0;
    clr_en   = 1'b0;
    load_cfg = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge && !stop_edge) begin
          state_d  = ST_CLEAR;
          load_cfg = 1'b1;
        end
      end
      ST_CLEAR: begin
        clr_en  = 1'b1;
        state_d = stop_edge ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (stop_edge) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          step_en = 1'b1;
          if (mode_q == MODE_SINGLE && span_hit) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (stop_edge) begin
          state_d = ST_IDLE;
        end else if (start_edge) begin
          state_d  = ST_CLEAR;
          load_cfg = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched configuration, prescaler, step count, direction and done pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q  <= MODE_CONT;
      dir_q   <= 1'b0;
      steps_q <= 8'd0;
      psc_q   <= 24'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_cfg) begin
        // Entering CLEAR: take the switch settings and zero the counters,
        // so CLEAR already presents the new direction and a zero count.
        mode_q  <= mode_sel;
        dir_q   <= dir_i;
        steps_q <= 8'd0;
        psc_q   <= 24'd0;
      end else if (state_q == ST_CLEAR) begin
        steps_q <= 8'd0;
        psc_q   <= 24'd0;
      end else if (state_q == ST_RUN && !stop_edge) begin
        psc_q <= tick ? 24'd0 : psc_q + 24'd1;
        if (step_en) begin
          unique case (mode_q)
            MODE_BOUNCE: begin
              // The reversal takes effect after the step, so the step
              // itself still moves in the old direction.
              if (span_hit) begin
                steps_q <= 8'd0;
                dir_q   <= ~dir_q;
              end else begin
                steps_q <= steps_q + 8'd1;
              end
            end
            MODE_SINGLE: begin
              steps_q <= steps_q + 8'd1;
              if (span_hit) begin
                done_q <= 1'b1;
              end
            end
            default: begin
              if (steps_q != STEPS_MAX) begin
                steps_q <= steps_q + 8'd1;
              end
            end
          endcase
        end
      end
    end
  end

  // The outputs decode only registered state.
  assign step_en_o = step_en;
  assign cnt_clr_o = clr_en;
  assign dir_o     = dir_q;
  assign state_o   = state_q;
  assign steps_o   = steps_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_johnson_sequencer.sv
// Directed-vector bench for johnson_sequencer, built with PSC = 4 and SPAN = 4.
// Each table row applies a set of input levels. The bench then advances
// 'rep' clocks and, after every one of those clocks, compares all outputs
// with the expected values given in the row.
module tb_johnson_sequencer;

  localparam int unsigned PSC  = 4;
  localparam int unsigned SPAN = 4;

  localparam int I = 0;  // IDLE
  localparam int C = 1;  // CLEAR
  localparam int R = 2;  // RUN
  localparam int H = 3;  // HALT

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       stop_i;
  logic [1:0] mode_i;
  logic       dir_i;
  logic       step_en_o;
  logic       dir_o;
  logic       cnt_clr_o;
  logic [1:0] state_o;
  logic [7:0] steps_o;
  logic       done_o;

  int checks   = 0;
  int failures = 0;

  johnson_sequencer #(.PSC(PSC), .SPAN(SPAN)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .mode_i    (mode_i),
    .dir_i     (dir_i),
    .step_en_o (step_en_o),
    .dir_o     (dir_o),
    .cnt_clr_o (cnt_clr_o),
    .state_o   (state_o),
    .steps_o   (steps_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       st;
    logic       sp;
    logic [1:0] md;
    logic       di;
    int         rep;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Output vector layout: {step_en, cnt_clr, dir, state[1:0], steps[7:0], done}.
  function automatic logic [13:0] mk(input int step, input int clr, input int dir,
                                     input int state, input int steps, input int done);
    return {1'(step), 1'(clr), 1'(dir), 2'(state), 8'(steps), 1'(done)};
  endfunction

  function automatic logic [13:0] outs();
    return {step_en_o, cnt_clr_o, dir_o, state_o, steps_o, done_o};
  endfunction

  task automatic add(input int st, input int sp, input int md, input int di, input int rep,
                     input int step, input int clr, input int dir, input int state,
                     input int steps, input int done);
    vec_t v;
    v.st  = 1'(st);
    v.sp  = 1'(sp);
    v.md  = 2'(md);
    v.di  = 1'(di);
    v.rep = rep;
    v.exp = mk(step, clr, dir, state, steps, done);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got step=%b clr=%b dir=%b state=%0d steps=%0d done=%b, want step=%b clr=%b dir=%b state=%0d steps=%0d done=%b",
               name, act[13], act[12], act[11], act[10:9], act[8:1], act[0],
               exp[13], exp[12], exp[11], exp[10:9], exp[8:1], exp[0]);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b1;
    stop_i  = 1'b0;
    mode_i  = 2'b00;
    dir_i   = 1'b0;

    // Reset with start held, then release reset while start stays high.
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("reset_%0d", i), outs(), mk(0, 0, 0, I, 0, 0));
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("held_start_%0d", i), outs(), mk(0, 0, 0, I, 0, 0));
    end

    // Continuous mode, dir 1. Mode and dir switches change after the start
    // edge and must be ignored. A start press in RUN must also be ignored.
    add(0,0,0,1,2, 0,0,0,I,0,0);
    add(1,0,0,1,1, 0,0,0,I,0,0);
    add(1,0,0,1,1, 0,1,1,C,0,0);
    add(0,0,1,0,3, 0,0,1,R,0,0);
    add(0,0,1,0,1, 1,0,1,R,0,0);
    add(1,0,1,0,3, 0,0,1,R,1,0);
    add(0,0,1,0,1, 1,0,1,R,1,0);
    for (int n = 2; n <= 4; n++) begin
      add(0,0,1,0,3, 0,0,1,R,n,0);
      add(0,0,1,0,1, 1,0,1,R,n,0);
    end
    // The stop edge lands exactly on the tick: the step is suppressed.
    add(0,0,1,0,3, 0,0,1,R,5,0);
    add(0,1,1,0,1, 0,0,1,R,5,0);
    add(0,1,1,0,1, 0,0,1,I,5,0);
    add(0,0,1,0,1, 0,0,1,I,5,0);

    // Bounce mode, dir 0: the direction reverses after steps 4 and 8.
    add(1,0,1,0,1, 0,0,1,I,5,0);
    add(1,0,1,0,1, 0,1,0,C,0,0);
    for (int n = 0; n <= 3; n++) begin
      add(0,0,1,0,3, 0,0,0,R,n,0);
      add(0,0,1,0,1, 1,0,0,R,n,0);
    end
    for (int n = 0; n <= 3; n++) begin
      add(0,0,1,0,3, 0,0,1,R,n,0);
      add(0,0,1,0,1, 1,0,1,R,n,0);
    end
    add(0,1,1,0,1, 0,0,0,R,0,0);
    add(0,1,1,0,1, 0,0,0,I,0,0);
    add(0,0,1,0,1, 0,0,0,I,0,0);

    // Single-shot mode, dir 1: four steps, then HALT with a done pulse.
    add(1,0,2,1,1, 0,0,0,I,0,0);
    add(1,0,2,1,1, 0,1,1,C,0,0);
    for (int n = 0; n <= 3; n++) begin
      add(0,0,2,1,3, 0,0,1,R,n,0);
      add(0,0,2,1,1, 1,0,1,R,n,0);
    end
    add(0,0,2,1,1, 0,0,1,H,4,1);
    add(0,0,2,1,3, 0,0,1,H,4,0);
    // Start and stop edges arrive together in HALT: the sequencer goes to IDLE.
    add(1,1,2,1,1, 0,0,1,H,4,0);
    add(1,1,2,1,1, 0,0,1,I,4,0);
    // A later start edge alone goes through CLEAR into RUN from zero.
    add(0,0,0,0,1, 0,0,1,I,4,0);
    add(1,0,0,0,1, 0,0,1,I,4,0);
    add(1,0,0,0,1, 0,1,0,C,0,0);
    add(0,0,0,0,3, 0,0,0,R,0,0);
    add(0,0,0,0,1, 1,0,0,R,0,0);
    add(0,0,0,0,1, 0,0,0,R,1,0);

    foreach (vecs[k]) begin
      start_i = vecs[k].st;
      stop_i  = vecs[k].sp;
      mode_i  = vecs[k].md;
      dir_i   = vecs[k].di;
      for (int r = 0; r < vecs[k].rep; r++) begin
        cycle();
        check($sformatf("row%0d_c%0d", k, r), outs(), vecs[k].exp);
      end
    end

    // Reset in the middle of RUN: every output returns to its reset value
    // and no clear pulse is issued.
    start_i = 1'b0;
    rst_ni  = 1'b0;
    cycle();
    check("midrun_reset", outs(), mk(0, 0, 0, I, 0, 0));
    rst_ni = 1'b1;
    cycle();
    check("post_reset_idle", outs(), mk(0, 0, 0, I, 0, 0));
    start_i = 1'b1;
    cycle();
    check("post_reset_press", outs(), mk(0, 0, 0, I, 0, 0));
    cycle();
    check("post_reset_clear", outs(), mk(0, 1, 0, C, 0, 0));
    cycle();
    check("post_reset_run", outs(), mk(0, 0, 0, R, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
